uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_baud_cnt.sv | 38 +++
 rtl/uart_tx_cfg.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  // FSM state encoding used by uart_tx_cfg.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Values of PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Stop-bit count selector values of STOP2.
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period timer: a down-counter that is loaded with (period-1) when a frame
// is accepted and reloads from the latched period on every terminal count.
// bit_end marks the last cycle of each bit while the transmitter is running.
module uart_tx_baud_cnt #(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load,
  input  logic               run,
  input  logic [PRESC_W-1:0] period,
  output logic               bit_end
);

  logic [PRESC_W-1:0] period_q;
  logic [PRESC_W-1:0] cnt_q;

  // Terminal count reached while a frame is active.
  assign bit_end = run && (cnt_q == '0);

  // Latch the period on load, then count down and reload at terminal count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= period;
      cnt_q    <= period - PRESC_W'(1);
    end else if (run) begin
      if (cnt_q == '0) begin
        cnt_q <= period_q - PRESC_W'(1);
      end else begin
        cnt_q <= cnt_q - PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first payload, optional
// parity, one or two stop bits. All outputs are registered.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line high, waiting for DATA_VALID
// ST_START  | driving the start bit (0)
// ST_DATA   | driving payload bit bit_idx_q
// ST_PARITY | driving the parity bit (only when latched PAR_EN=1)
// ST_STOP   | driving stop bit(s) (1); stop_idx_q counts them
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESC_W-1:0]    PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e state_q;
  tx_state_e state_nxt;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [IDX_W-1:0]      bit_idx_nxt;
  logic                  stop_idx_q;
  logic                  stop_idx_nxt;

  logic                  accept;
  logic                  bit_end;
  logic                  par_bit;
  logic [PRESC_W-1:0]    presc_eff;

  logic                  tx_d;
  logic                  busy_d;
  logic                  done_d;

  // A prescale of zero behaves like one cycle per bit.
  assign presc_eff = (PRESCALE == '0) ? PRESC_W'(1) : PRESCALE;

  // BUSY is always low in IDLE; it is kept in the term so the acceptance
  // condition reads exactly as the handshake is defined.
  assign accept = (state_q == ST_IDLE) && DATA_VALID && !BUSY;

  // Even parity is the XOR of the payload; odd parity is its inverse.
  assign par_bit = (par_typ_q == PAR_ODD) ? ~(^data_q) : (^data_q);

  uart_tx_baud_cnt #(
    .PRESC_W (PRESC_W)
  ) u_baud_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .load    (accept),
    .run     (state_q != ST_IDLE),
    .period  (presc_eff),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; every transition except acceptance waits for bit_end.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_nxt = ST_START;
      end
      ST_START: begin
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_idx_q == LAST_IDX)) begin
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end && (stop_idx_q == stop2_q)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the bit-index and stop-bit counters, shared by the
  // counter registers and the output decode so TX_OUT can be registered.
  always_comb begin
    bit_idx_nxt  = bit_idx_q;
    stop_idx_nxt = stop_idx_q;
    if (accept) begin
      bit_idx_nxt  = '0;
      stop_idx_nxt = 1'b0;
    end else if (bit_end) begin
      if ((state_q == ST_DATA) && (bit_idx_q != LAST_IDX)) begin
        bit_idx_nxt = bit_idx_q + IDX_W'(1);
      end
      if (state_q == ST_STOP) begin
        stop_idx_nxt = 1'b1;
      end
    end
  end

  // Output decode from the next state, so outputs change with the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_nxt != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_nxt == ST_IDLE);
    unique case (state_nxt)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_q[bit_idx_nxt];
      ST_PARITY: tx_d = par_bit;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // Registered outputs; reset drives the line to idle immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      TX_OUT <= tx_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
    end
  end

  // Frame configuration latched on acceptance; ignored inputs mid-frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= STOP_ONE;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      stop2_q   <= STOP2;
    end
  end

  // Bit-index and stop-bit counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      bit_idx_q  <= bit_idx_nxt;
      stop_idx_q <= stop_idx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit and a 7-bit instance, expected
// line sequences written out by hand, one character per bit in time order.
module tb_uart_tx_cfg;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       dv8 = 1'b0;
  logic       dv7 = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [5:0] PRESCALE = '0;

  logic tx8, busy8, done8;
  logic tx7, busy7, done7;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  uart_tx_cfg #(.DATA_WIDTH(8), .PRESC_W(6)) dut8 (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (dv8),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (tx8),
    .BUSY       (busy8),
    .DONE       (done8)
  );

  uart_tx_cfg #(.DATA_WIDTH(7), .PRESC_W(6)) dut7 (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA[6:0]),
    .DATA_VALID (dv7),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (tx7),
    .BUSY       (busy7),
    .DONE       (done7)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input int sel);
    chk({tag, "_tx"},   (sel == 0) ? tx8   : tx7,   1);
    chk({tag, "_busy"}, (sel == 0) ? busy8 : busy7, 0);
    chk({tag, "_done"}, (sel == 0) ? done8 : done7, 0);
  endtask

  // Called at a negedge. Requests a frame, scrambles the inputs after
  // acceptance, checks every cycle of the line, and returns at the negedge
  // of the DONE cycle. pulse_at >= 0 re-asserts DATA_VALID mid-frame.
  task automatic send(input string tag, input int sel, input logic [7:0] d,
                      input logic pe, input logic pt, input logic s2,
                      input logic [5:0] ps, input string seq, input int n_per,
                      input int pulse_at);
    int  cyc;
    byte c;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = ps;
    dv8 = (sel == 0);
    dv7 = (sel == 1);
    @(posedge CLK);
    #1;
    dv8 = 1'b0;
    dv7 = 1'b0;
    P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2; PRESCALE = ps + 6'd3;
    cyc = 0;
    for (int i = 0; i < seq.len(); i++) begin
      c = seq[i];
      for (int j = 0; j < n_per; j++) begin
        @(negedge CLK);
        chk($sformatf("%s_tx_b%0d_c%0d", tag, i, j), (sel == 0) ? tx8 : tx7, (c == 8'h31) ? 1 : 0);
        chk($sformatf("%s_busy_c%0d", tag, cyc), (sel == 0) ? busy8 : busy7, 1);
        chk($sformatf("%s_done_c%0d", tag, cyc), (sel == 0) ? done8 : done7, 0);
        if (cyc == pulse_at) begin
          dv8 = (sel == 0);
          dv7 = (sel == 1);
          P_DATA = 8'h54;
        end else begin
          dv8 = 1'b0;
          dv7 = 1'b0;
        end
        cyc++;
      end
    end
    @(negedge CLK);
    chk({tag, "_done_pulse"}, (sel == 0) ? done8 : done7, 1);
    chk({tag, "_busy_end"},   (sel == 0) ? busy8 : busy7, 0);
    chk({tag, "_tx_end"},     (sel == 0) ? tx8   : tx7,   1);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk_idle("rst8", 0);
    chk_idle("rst7", 1);
    RST = 1'b1;
    @(negedge CLK);
    chk_idle("post_rst8", 0);

    // 0xA8 odd parity, 1 cycle/bit; DATA_VALID with 0x54 pulsed mid-frame.
    send("a8_odd", 0, 8'hA8, 1'b1, 1'b1, 1'b0, 6'd1, "00001010101", 1, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk_idle($sformatf("no_second_%0d", k), 0);
    end

    // 0x54 even parity, 4 cycles/bit: 44 busy cycles.
    send("54_even_p4", 0, 8'h54, 1'b1, 1'b0, 1'b0, 6'd4, "00010101011", 4, -1);
    // Back-to-back: accepted on the edge ending the DONE cycle.
    send("00_even_s2_p3", 0, 8'h00, 1'b1, 1'b0, 1'b1, 6'd3, "000000000011", 3, -1);
    @(negedge CLK);
    chk_idle("gap_after_b2b", 0);

    // Reset during DATA state with the line low.
    P_DATA = 8'hA8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 6'd2;
    dv8 = 1'b1;
    @(posedge CLK);
    #1;
    dv8 = 1'b0;
    repeat (5) @(negedge CLK);
    chk("pre_rst_busy", busy8, 1);
    chk("pre_rst_tx", tx8, 0);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_tx", tx8, 1);
    chk("async_rst_busy", busy8, 0);
    chk("async_rst_done", done8, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk_idle("after_rst", 0);

    // 0xCA no parity, two stop bits.
    send("ca_np_s2", 0, 8'hCA, 1'b0, 1'b0, 1'b1, 6'd1, "00101001111", 1, -1);
    @(negedge CLK);

    // 7-bit instance, 0x7F odd parity, PRESCALE=0 behaves as 1.
    send("7f_w7_p0", 1, 8'h7F, 1'b1, 1'b1, 1'b0, 6'd0, "0111111101", 1, -1);
    @(negedge CLK);
    chk_idle("w7_idle", 1);
    chk_idle("w8_quiet", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
